// File: rtl/ifid_fetch_buffer.sv
// ifid_fetch_buffer
//   Instruction fetch buffer that sits between the PC/instruction-memory fetch
//   path and the decode stage. Each fetched (pc, instruction) pair goes into a
//   small circular FIFO. Decode reads it through a valid/ready handshake, so a
//   decode stall never loses a fetched word. A synchronous flush empties the
//   buffer on a taken branch/jump redirect.
//
// Parameters
//   DEPTH     number of buffered entries (power of two, >= 2)
//   RESET_PC  value driven on out_pc while the buffer is empty
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   fetch offers in_pc/in_instr this cycle
//   in_ready   buffer accepts the offer (not full, no flush)
//   in_pc      byte address of the fetched instruction
//   in_instr   fetched instruction word
//   flush      discard all entries at the next edge
//   out_valid  head entry valid for decode
//   out_ready  decode consumes the head this cycle
//   out_pc     pc of the head entry (RESET_PC when empty)
//   out_instr  instruction of the head entry (32'h0 when empty)
//   count      current occupancy
//   out_exc    address-error flag of the head entry (IFID_ADEL_EN builds only)
//
// Optional feature: define IFID_ADEL_EN to tag each entry with a misaligned-PC
// flag. A flagged entry raises out_exc and presents a nop on out_instr.

module ifid_fetch_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
`ifdef IFID_ADEL_EN
    output logic                     out_exc,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Control state
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Entry storage; data only, never reset
    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];
`ifdef IFID_ADEL_EN
    logic          r_adel  [DEPTH];
`endif

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);

    // No bypass: a full buffer refuses input even if decode pops this cycle.
    assign in_ready  = ~w_full & ~flush;
    assign out_valid = ~w_empty;
    assign count     = r_count;

    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Stage boundary: pointer/occupancy update at the clock edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            // Redirect wins over push and pop; a popped head is still
            // considered consumed by decode.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // w_push already excludes flush and full, so a valid entry is never
    // overwritten.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wptr]    <= in_pc;
            r_instr[r_wptr] <= in_instr;
`ifdef IFID_ADEL_EN
            r_adel[r_wptr]  <= (in_pc[1:0] != 2'b00);
`endif
        end
    end

    // Stage boundary: head entry presented to decode from registered storage
    always_comb begin
        out_pc    = RESET_PC;
        out_instr = 32'h0;
`ifdef IFID_ADEL_EN
        out_exc   = 1'b0;
`endif
        if (out_valid) begin
            out_pc    = r_pc[r_rptr];
            out_instr = r_instr[r_rptr];
`ifdef IFID_ADEL_EN
            out_exc   = r_adel[r_rptr];
            if (r_adel[r_rptr]) begin
                out_instr = 32'h0;
            end
`endif
        end
    end

endmodule
